// File: rtl/fpu_wb_sched.sv
// FP op decode, issue and writeback-slot scheduler for a fixed-latency FMA pipeline.
// Optional feature: define FPU_FLAGS_ACCUM_EN for sticky accumulated exception flags.
module fpu_wb_sched #(
  parameter int TAG_W   = 5,
  parameter int LAT_ADD = 4,
  parameter int LAT_MUL = 5,
  parameter int LAT_FMA = 6,
  parameter int MAX_LAT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_funct7,
  input  logic [2:0]       req_funct3,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       frm,
  output logic             iss_valid,
  output logic [2:0]       iss_op_type,
  output logic [2:0]       iss_rm,
  output logic [TAG_W-1:0] iss_tag,
  input  logic [4:0]       pipe_flags,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic             err_valid,
  output logic [TAG_W-1:0] err_tag,
  input  logic             flush,
  input  logic             fflags_clr,
  output logic [4:0]       fflags,
  output logic             busy
);

  generate
    if (LAT_ADD < 2 || LAT_ADD > MAX_LAT || LAT_MUL < 2 || LAT_MUL > MAX_LAT ||
        LAT_FMA < 2 || LAT_FMA > MAX_LAT) begin : g_lat_check
      $error("fpu_wb_sched: every LAT_* must lie in 2..MAX_LAT");
    end
  endgenerate

  logic             slot_v [MAX_LAT];
  logic [TAG_W-1:0] slot_t [MAX_LAT];

  logic       cls_legal;
  logic       rm_legal;
  logic       legal;
  logic [2:0] op_type;
  logic [2:0] rm;
  int         lat;
  logic       lat_busy;
  logic       accept;

  always_comb begin
    cls_legal = 1'b0;
    op_type   = 3'b000;
    lat       = LAT_ADD;
    case (req_funct7[6:2])
      5'b00000: begin cls_legal = 1'b1; op_type = 3'b000; lat = LAT_ADD; end
      5'b00001: begin cls_legal = 1'b1; op_type = 3'b001; lat = LAT_ADD; end
      5'b00010: begin cls_legal = 1'b1; op_type = 3'b010; lat = LAT_MUL; end
      5'b10000: begin
        cls_legal = 1'b1;
        op_type   = 3'b011 + {1'b0, req_funct7[1:0]};
        lat       = LAT_FMA;
      end
      default: ;
    endcase
    rm       = (req_funct3 == 3'b111) ? frm : req_funct3;
    rm_legal = (rm <= 3'b100);
    legal    = cls_legal & rm_legal;
    // slot[L] would shift into slot[L-1] at the same edge we write it; slot[MAX_LAT] is always free.
    lat_busy = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (slot_v[i] && lat == i) lat_busy = 1'b1;
    end
  end

  // Handshake: a request transfers on a cycle where req_valid && req_ready; the requester holds
  // its fields stable while req_valid is high and req_ready is low. Illegal ops are always
  // taken (unless flushing) so they can retire through err_valid without occupying a slot.
  assign req_ready   = ~flush & (~legal | ~lat_busy);
  assign accept      = req_valid & req_ready;
  assign iss_valid   = accept & legal;
  assign iss_op_type = op_type;
  assign iss_rm      = rm;
  assign iss_tag     = req_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        slot_v[i] <= 1'b0;
        slot_t[i] <= '0;
      end
      err_valid <= 1'b0;
      err_tag   <= '0;
    end else if (flush) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        slot_v[i] <= 1'b0;
      end
      err_valid <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_LAT - 1; i++) begin
        slot_v[i] <= slot_v[i+1];
        slot_t[i] <= slot_t[i+1];
      end
      slot_v[MAX_LAT-1] <= 1'b0;
      for (int i = 0; i < MAX_LAT; i++) begin
        if (iss_valid && lat == i + 1) begin
          slot_v[i] <= 1'b1;
          slot_t[i] <= req_tag;
        end
      end
      err_valid <= accept & ~legal;
      err_tag   <= req_tag;
    end
  end

  assign wb_valid = slot_v[0];
  assign wb_tag   = slot_t[0];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) busy = busy | slot_v[i];
  end

`ifdef FPU_FLAGS_ACCUM_EN
  logic [4:0] flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 5'b0;
    else     flags_q <= (fflags_clr ? 5'b0 : flags_q) | (wb_valid ? pipe_flags : 5'b0);
  end

  assign fflags = flags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr;
  assign fflags = wb_valid ? pipe_flags : 5'b0;
`endif

endmodule

// File: tb/tb_fpu_wb_sched.sv
// Self-checking bench for fpu_wb_sched: directed scenarios plus a randomized run
// against a cycle-indexed writeback-schedule model.
module tb_fpu_wb_sched;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [6:0]       req_funct7 = '0;
  logic [2:0]       req_funct3 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [2:0]       frm = '0;
  logic             iss_valid;
  logic [2:0]       iss_op_type;
  logic [2:0]       iss_rm;
  logic [TAG_W-1:0] iss_tag;
  logic [4:0]       pipe_flags = '0;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic             err_valid;
  logic [TAG_W-1:0] err_tag;
  logic             flush = 1'b0;
  logic             fflags_clr = 1'b0;
  logic [4:0]       fflags;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  // reference model: writeback tag keyed by the cycle it must appear; err tags awaiting retire
  logic [TAG_W-1:0] sched_t [int];
  logic [TAG_W-1:0] exp_q [$];

  fpu_wb_sched #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct7(req_funct7), .req_funct3(req_funct3), .req_tag(req_tag), .frm(frm),
    .iss_valid(iss_valid), .iss_op_type(iss_op_type), .iss_rm(iss_rm), .iss_tag(iss_tag),
    .pipe_flags(pipe_flags), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .err_valid(err_valid), .err_tag(err_tag), .flush(flush), .fflags_clr(fflags_clr),
    .fflags(fflags), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic drive_req(input logic v, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [TAG_W-1:0] tag);
    req_valid  = v;
    req_funct7 = f7;
    req_funct3 = f3;
    req_tag    = tag;
  endtask

  task automatic idle(input int n);
    drive_req(1'b0, 7'b0, 3'b0, '0);
    flush = 1'b0; fflags_clr = 1'b0; pipe_flags = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({wb_valid, wb_tag, err_valid, err_tag, fflags, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got wb=%b/%h err=%b/%h fflags=%b busy=%b, expected all 0",
               wb_valid, wb_tag, err_valid, err_tag, fflags, busy);
    end
    @(negedge clk); rst = 1'b0; #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_fadd;
    @(negedge clk); drive_req(1'b1, 7'b0000000, 3'b000, 5'd3); #1;
    n_vec++;
    if ({iss_valid, iss_op_type, iss_rm, iss_tag} !== {1'b1, 3'b000, 3'b000, 5'd3}) begin
      n_err++;
      $display("FAIL fadd_issue: got v=%b op=%b rm=%b tag=%h expected 1/000/000/03",
               iss_valid, iss_op_type, iss_rm, iss_tag);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); if (k == 1) drive_req(1'b0, 7'b0, 3'b0, '0); #1;
      n_vec++;
      if (wb_valid !== (k == 4) || (k == 4 && wb_tag !== 5'd3)) begin
        n_err++;
        $display("FAIL fadd_wb cycle %0d: got wb=%b tag=%h expected wb=%b tag=03",
                 k, wb_valid, wb_tag, k == 4);
      end
    end
  endtask

  task automatic test_stall;
    @(negedge clk); drive_req(1'b1, 7'b1000000, 3'b000, 5'd1); #1;
    n_vec++;
    if (iss_valid !== 1'b1 || iss_op_type !== 3'b011) begin
      n_err++; $display("FAIL fmadd_issue: got v=%b op=%b expected 1/011", iss_valid, iss_op_type);
    end
    @(negedge clk); drive_req(1'b0, 7'b0, 3'b0, '0);
    @(negedge clk); drive_req(1'b1, 7'b0000000, 3'b000, 5'd2); #1;
    n_vec++;
    if (req_ready !== 1'b0 || iss_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_c2: got ready=%b iss=%b expected 0/0", req_ready, iss_valid);
    end
    @(negedge clk); #1;
    n_vec++;
    if (req_ready !== 1'b1 || iss_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_c3: got ready=%b iss=%b expected 1/1", req_ready, iss_valid);
    end
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk); if (c == 4) drive_req(1'b0, 7'b0, 3'b0, '0); #1;
      n_vec++;
      if (wb_valid !== (c == 6 || c == 7) ||
          (c == 6 && wb_tag !== 5'd1) || (c == 7 && wb_tag !== 5'd2)) begin
        n_err++;
        $display("FAIL stall_wb cycle %0d: got wb=%b tag=%h", c, wb_valid, wb_tag);
      end
    end
  endtask

  task automatic test_illegal;
    logic [6:0] f7s [2];
    logic [4:0] tags [2];
    f7s[0] = 7'b0001000; tags[0] = 5'd9;   // FMUL, dynamic rm resolving to 101
    f7s[1] = 7'b0001100; tags[1] = 5'd5;   // unlisted class 00011
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); frm = 3'b101;
      drive_req(1'b1, f7s[t], (t == 0) ? 3'b111 : 3'b000, tags[t]); #1;
      n_vec++;
      if (req_ready !== 1'b1 || iss_valid !== 1'b0) begin
        n_err++;
        $display("FAIL illegal_accept %0d: got ready=%b iss=%b expected 1/0", t, req_ready, iss_valid);
      end
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk); if (c == 1) drive_req(1'b0, 7'b0, 3'b0, '0); #1;
        n_vec++;
        if (err_valid !== (c == 1) || (c == 1 && err_tag !== tags[t]) || wb_valid !== 1'b0) begin
          n_err++;
          $display("FAIL illegal_err %0d cycle %0d: got err=%b tag=%h wb=%b", t, c, err_valid,
                   err_tag, wb_valid);
        end
      end
    end
    frm = 3'b000;
  endtask

  task automatic test_flush;
    @(negedge clk); drive_req(1'b1, 7'b0000000, 3'b000, 5'd4);
    @(negedge clk); drive_req(1'b1, 7'b0001000, 3'b000, 5'd5);
    @(negedge clk); drive_req(1'b1, 7'b1000000, 3'b000, 5'd6);
    @(negedge clk); flush = 1'b1; drive_req(1'b1, 7'b0000000, 3'b000, 5'd7); #1;
    n_vec++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || iss_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_cycle: got busy=%b ready=%b iss=%b expected 1/0/0", busy, req_ready, iss_valid);
    end
    @(negedge clk); flush = 1'b0; drive_req(1'b0, 7'b0, 3'b0, '0); #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL flush_busy: got %b expected 0", busy);
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (wb_valid !== 1'b0 || err_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_wb cycle %0d: got wb=%b err=%b expected 0", c, wb_valid, err_valid);
      end
    end
  endtask

  task automatic test_flags;
    logic [4:0] pf [4];
    logic [4:0] exp_f [5];
    pf[0] = 5'b00001; pf[1] = 5'b10000; pf[2] = 5'b00100; pf[3] = 5'b11111;
`ifdef FPU_FLAGS_ACCUM_EN
    exp_f[0] = 5'b00000; exp_f[1] = 5'b00001; exp_f[2] = 5'b10001;
    exp_f[3] = 5'b00100; exp_f[4] = 5'b00100;
`else
    exp_f[0] = 5'b00001; exp_f[1] = 5'b10000; exp_f[2] = 5'b00100;
    exp_f[3] = 5'b00000; exp_f[4] = 5'b00000;
`endif
    @(negedge clk); fflags_clr = 1'b1;
    @(negedge clk); fflags_clr = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      drive_req(c <= 2, 7'b0000000, 3'b000, 5'(c + 1));
      pipe_flags = (c >= 4 && c <= 7) ? pf[c-4] : 5'b00000;
      fflags_clr = (c == 6);
      #1;
      if (c >= 4) begin
        n_vec++;
        if (fflags !== exp_f[c-4]) begin
          n_err++; $display("FAIL flags cycle %0d: got %b expected %b", c, fflags, exp_f[c-4]);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_async_reset;
    @(negedge clk); drive_req(1'b1, 7'b0000000, 3'b000, 5'd7);
    @(negedge clk); drive_req(1'b1, 7'b0001000, 3'b000, 5'd8);
    @(negedge clk); drive_req(1'b0, 7'b0, 3'b0, '0); #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL arst_pre_busy: got %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({wb_valid, wb_tag, err_valid, err_tag, fflags, busy} !== '0) begin
      n_err++;
      $display("FAIL arst_outputs: got wb=%b busy=%b fflags=%b err=%b expected 0", wb_valid, busy,
               fflags, err_valid);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (wb_valid !== 1'b0) begin
        n_err++; $display("FAIL arst_wb cycle %0d: got %b expected 0", c, wb_valid);
      end
    end
  endtask

  task automatic test_random;
    int cyc;
    int sel;
    int lat;
    logic [4:0] cls;
    logic [2:0] rm, op;
    logic cls_ok, legal, wb_now, err_now, exp_ready, exp_iss;
    logic [4:0] acc;
    logic [4:0] exp_ff;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sched_t.delete(); exp_q.delete(); acc = '0; cyc = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      sel = $urandom_range(0, 6);
      case (sel)
        0, 6: req_funct7 = 7'b0000000;
        1: req_funct7 = 7'b0000100;
        2: req_funct7 = 7'b0001000;
        3: req_funct7 = {5'b10000, 2'($urandom_range(0, 3))};
        4: req_funct7 = {5'($urandom_range(3, 15)), 2'($urandom_range(0, 3))};
        default: req_funct7 = 7'($urandom_range(0, 127));
      endcase
      req_funct3 = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      req_valid  = ($urandom_range(0, 9) < 6);
      req_tag    = 5'($urandom_range(0, 31));
      frm        = 3'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 99) < 4);
      fflags_clr = ($urandom_range(0, 9) == 0);
      pipe_flags = 5'($urandom_range(0, 31));
      #1;
      cls = req_funct7[6:2];
      cls_ok = 1'b1; lat = 4; op = 3'b000;
      if (cls == 5'd0) begin op = 3'd0; lat = 4; end
      else if (cls == 5'd1) begin op = 3'd1; lat = 4; end
      else if (cls == 5'd2) begin op = 3'd2; lat = 5; end
      else if (cls == 5'd16) begin op = 3'(3 + req_funct7[1:0]); lat = 6; end
      else cls_ok = 1'b0;
      rm = (req_funct3 == 3'b111) ? frm : req_funct3;
      legal = cls_ok && (rm < 3'd5);
      wb_now = sched_t.exists(cyc);
      err_now = (exp_q.size() > 0);
      exp_ready = !flush && (!legal || !sched_t.exists(cyc + lat));
      exp_iss = req_valid && exp_ready && legal;
`ifdef FPU_FLAGS_ACCUM_EN
      exp_ff = acc;
`else
      exp_ff = wb_now ? pipe_flags : 5'b0;
`endif
      n_vec++;
      if (req_ready !== exp_ready || iss_valid !== exp_iss ||
          (exp_iss && {iss_op_type, iss_rm, iss_tag} !== {op, rm, req_tag})) begin
        n_err++;
        $display("FAIL rnd_issue cyc %0d: got rdy=%b iss=%b op=%b rm=%b expected %b/%b/%b/%b",
                 cyc, req_ready, iss_valid, iss_op_type, iss_rm, exp_ready, exp_iss, op, rm);
      end
      n_vec++;
      if (wb_valid !== wb_now || (wb_now && wb_tag !== sched_t[cyc])) begin
        n_err++;
        $display("FAIL rnd_wb cyc %0d: got wb=%b tag=%h expected wb=%b", cyc, wb_valid, wb_tag, wb_now);
      end
      n_vec++;
      if (err_valid !== err_now || (err_now && err_tag !== exp_q[0])) begin
        n_err++;
        $display("FAIL rnd_err cyc %0d: got err=%b tag=%h expected err=%b", cyc, err_valid, err_tag, err_now);
      end
      n_vec++;
      if (busy !== (sched_t.num() != 0) || fflags !== exp_ff) begin
        n_err++;
        $display("FAIL rnd_busy_flags cyc %0d: got busy=%b ff=%b expected %b/%b", cyc, busy, fflags,
                 sched_t.num() != 0, exp_ff);
      end
      acc = (fflags_clr ? 5'b0 : acc) | (wb_now ? pipe_flags : 5'b0);
      if (wb_now) sched_t.delete(cyc);
      if (err_now) void'(exp_q.pop_front());
      if (flush) begin
        sched_t.delete();
        exp_q.delete();
      end else if (req_valid && exp_ready) begin
        if (legal) sched_t[cyc + lat] = req_tag;
        else exp_q.push_back(req_tag);
      end
      cyc++;
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_fadd();
    idle(2);
    test_stall();
    idle(2);
    test_illegal();
    idle(2);
    test_flush();
    idle(2);
    test_flags();
    idle(2);
    test_async_reset();
    idle(2);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
